// File: rtl/mfcc_fifo_wr_arbiter.sv
// Round-robin arbiter sharing the MFCC output FIFO push port between N_REQ producers, plus FIFO level tracking.
// Zero-cycle latency: the winning beat reaches wren/push_data in the same cycle it is presented.
// fifo_full stalls all producers and freezes arbitration state; MFCC_ARB_BURST_EN enables burst grant locking.
module mfcc_fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 20,
    parameter int MAX_BURST = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*DATA_W-1:0]       req_data,
    output logic [N_REQ-1:0]              req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_empty,
    input  logic                          fifo_rden,
    output logic                          wren,
    output logic [DATA_W-1:0]             push_data,
    output logic [$clog2(N_REQ)-1:0]      grant_id,
    output logic [$clog2(DEPTH+1)-1:0]    level
);

    localparam int IDW = $clog2(N_REQ);
    localparam int LVW = $clog2(DEPTH+1);

    if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 1) begin : g_bad_params
        $error("mfcc_fifo_wr_arbiter: illegal parameter set");
    end

    function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] id);
        return (int'(id) == N_REQ - 1) ? '0 : id + 1'b1;
    endfunction

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] rr_ptr_d;
    logic [IDW-1:0] search_base;
    logic           lock_hold;
    logic           found;
    logic [IDW-1:0] winner;
    logic           accept;
    logic           pop;

`ifdef MFCC_ARB_BURST_EN
    localparam int CW = $clog2(MAX_BURST+1);

    typedef enum logic {IDLE, LOCK} arb_state_t;

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic [CW-1:0]  burst_cnt_q, burst_cnt_d;
    logic           lock_drop;

    // A lock whose owner went idle is released in the same cycle, so the
    // search already starts past the old owner.
    assign lock_hold   = (state_q == LOCK) && req_valid[lock_id_q];
    assign lock_drop   = (state_q == LOCK) && !req_valid[lock_id_q];
    assign search_base = lock_drop ? rr_next(lock_id_q) : rr_ptr;
`else
    assign lock_hold   = 1'b0;
    assign search_base = rr_ptr;
`endif

    // Walk the ring backwards so the last hit is the first one after search_base.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        if (lock_hold) begin
            found  = 1'b1;
`ifdef MFCC_ARB_BURST_EN
            winner = lock_id_q;
`endif
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                int idx;
                idx = int'(search_base) + k;
                if (idx >= N_REQ) idx = idx - N_REQ;
                if (req_valid[idx]) begin
                    found  = 1'b1;
                    winner = IDW'(idx);
                end
            end
        end
    end

    assign accept = found && !fifo_full && rstn;
    assign pop    = fifo_rden && !fifo_empty;

    always_comb begin
        wren      = accept;
        req_ready = '0;
        grant_id  = '0;
        push_data = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
            grant_id          = winner;
            push_data         = req_data[int'(winner)*DATA_W +: DATA_W];
        end
    end

`ifdef MFCC_ARB_BURST_EN
    always_comb begin
        state_d     = state_q;
        lock_id_d   = lock_id_q;
        burst_cnt_d = burst_cnt_q;
        rr_ptr_d    = rr_ptr;
        if (!fifo_full) begin
            if (lock_drop) begin
                state_d     = IDLE;
                burst_cnt_d = '0;
                rr_ptr_d    = rr_next(lock_id_q);
            end
            if (accept) begin
                rr_ptr_d = rr_next(winner);
                if (lock_hold) begin
                    if (burst_cnt_q == CW'(MAX_BURST - 1)) begin
                        state_d     = IDLE;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end else if (MAX_BURST > 1) begin
                    state_d     = LOCK;
                    lock_id_d   = winner;
                    burst_cnt_d = CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            lock_id_q   <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lock_id_q   <= lock_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    assign rr_ptr_d = accept ? rr_next(winner) : rr_ptr;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_d;
        end
    end

    // Simultaneous push and pop cancel; both ends saturate rather than wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   if (level != LVW'(DEPTH)) level <= level + 1'b1;
                2'b01:   if (level != '0)          level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_mfcc_fifo_wr_arbiter.sv
// Table-driven and randomized checks of mfcc_fifo_wr_arbiter against a queue-free reference model.
module tb_mfcc_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 20;
    localparam int MAXB  = 4;
`ifdef MFCC_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fifo_full, fifo_empty, fifo_rden;
    logic              wren;
    logic [DW-1:0]     push_data;
    logic [1:0]        grant_id;
    logic [4:0]        level;

    always #5 clk = ~clk;

    mfcc_fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_rden(fifo_rden), .wren(wren), .push_data(push_data),
        .grant_id(grant_id), .level(level)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_ptr, m_level, m_lock_id, m_cnt;
    bit m_lock;

    typedef struct {
        logic [3:0] valid;
        logic       full;
        logic       rden;
        logic       empty;
        logic       exp_wren;
        int         exp_gid;
        int         exp_level;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ptr = 0; m_level = 0; m_lock = 0; m_lock_id = 0; m_cnt = 0;
    endfunction

    function automatic int model_winner(input logic [3:0] v);
        int start;
        if (BURST && m_lock && v[m_lock_id]) return m_lock_id;
        start = (BURST && m_lock) ? (m_lock_id + 1) % N : m_ptr;
        for (int k = 0; k < N; k++)
            if (v[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    function automatic void model_update(input logic [3:0] v, input logic f, input logic r,
                                         input logic e, input int w);
        bit acc, dec;
        acc = (w >= 0) && !f;
        dec = r && !e;
        if (!f) begin
            if (BURST && m_lock && !v[m_lock_id]) begin
                m_lock = 0; m_cnt = 0; m_ptr = (m_lock_id + 1) % N;
            end
            if (acc) begin
                m_ptr = (w + 1) % N;
                if (BURST) begin
                    if (m_lock) begin
                        m_cnt++;
                        if (m_cnt == MAXB) begin m_lock = 0; m_cnt = 0; end
                    end else if (MAXB > 1) begin
                        m_lock = 1; m_lock_id = w; m_cnt = 1;
                    end
                end
            end
        end
        if (acc && !dec && m_level < DEPTH) m_level++;
        else if (dec && !acc && m_level > 0) m_level--;
    endfunction

    function automatic void add(input logic [3:0] v, input logic f, input logic r, input logic e,
                                input logic ew, input int eg, input int el);
        vec_t t;
        t.valid = v; t.full = f; t.rden = r; t.empty = e;
        t.exp_wren = ew; t.exp_gid = eg; t.exp_level = el;
        tbl.push_back(t);
    endfunction

    // One clock: drive, compare against model (and optionally a table row), advance.
    task automatic cycle(input logic [3:0] v, input logic f, input logic r, input logic e,
                         input bit use_tbl, input logic ew, input int eg, input int el);
        int  w;
        bit  acc;
        logic [N-1:0] rdy;
        req_valid = v; fifo_full = f; fifo_rden = r; fifo_empty = e;
        #2;
        w   = model_winner(v);
        acc = (w >= 0) && !f;
        rdy = '0;
        if (acc) rdy[w] = 1'b1;
        check("wren", 64'(wren), 64'(acc));
        check("req_ready", 64'(req_ready), 64'(rdy));
        check("grant_id", 64'(grant_id), acc ? 64'(w) : 64'd0);
        if (acc) check("push_data", 64'(push_data), 64'(req_data[w*DW +: DW]));
        check("level", 64'(level), 64'(m_level));
        if (use_tbl) begin
            check("tbl_wren", 64'(wren), 64'(ew));
            check("tbl_grant", 64'(grant_id), 64'(eg));
            check("tbl_level", 64'(level), 64'(el));
        end
        model_update(v, f, r, e, w);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        req_valid = 4'hF; fifo_full = 1'b0; fifo_rden = 1'b0; fifo_empty = 1'b1;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'hA5A5_0000 | i;
        model_reset();
        #3;
        check("reset_wren", 64'(wren), 64'd0);
        check("reset_ready", 64'(req_ready), 64'd0);
        check("reset_level", 64'(level), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;

`ifdef MFCC_ARB_BURST_EN
        for (int i = 0; i < 8; i++) add(4'b0011, 0, 0, 1, 1, i / 4, i);
        add(4'b0011, 0, 0, 1, 1, 0, 8);
        add(4'b0011, 0, 0, 1, 1, 0, 9);
        add(4'b0010, 0, 0, 1, 1, 1, 10);   // req 0 drops: req 1 wins same cycle
        for (int i = 0; i < 3; i++) add(4'b0010, 0, 0, 1, 1, 1, 11 + i);
        add(4'b0001, 0, 0, 1, 1, 0, 14);
        add(4'b0011, 1, 0, 1, 0, 0, 15);   // full while locked
        add(4'b0011, 0, 0, 1, 1, 0, 15);
        add(4'b0000, 0, 0, 1, 0, 0, 16);
`else
        for (int i = 0; i < 8; i++) add(4'hF, 0, 0, 1, 1, i % 4, i);
        for (int i = 0; i < 3; i++) add(4'b0100, 0, 0, 1, 1, 2, 8 + i);
        add(4'hF, 1, 0, 1, 0, 0, 11);
        add(4'hF, 1, 0, 1, 0, 0, 11);
        add(4'hF, 0, 0, 1, 1, 3, 11);      // resumes at rr_ptr=3
        add(4'hF, 0, 0, 1, 1, 0, 12);
        for (int i = 0; i < 8; i++) add(4'b0000, 0, 1, 0, 0, 0, 13 - i);
        add(4'b0001, 0, 1, 0, 1, 0, 5);    // push+pop together
        add(4'b0000, 0, 0, 1, 0, 0, 5);
        add(4'b0010, 0, 1, 1, 1, 1, 5);    // pop while empty ignored
        add(4'b0000, 0, 0, 1, 0, 0, 6);
`endif
        foreach (tbl[i])
            cycle(tbl[i].valid, tbl[i].full, tbl[i].rden, tbl[i].empty,
                  1'b1, tbl[i].exp_wren, tbl[i].exp_gid, tbl[i].exp_level);

        // Saturation at DEPTH
        for (int i = 0; i < 25; i++) cycle(4'hF, 0, 0, 0, 0, 0, 0, 0);
        #2 check("level_sat", 64'(level), 64'(DEPTH));
        #1;
        cycle(4'hF, 0, 0, 0, 0, 0, 0, 0);
        #2 check("level_sat_hold", 64'(level), 64'(DEPTH));
        @(posedge clk); #1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] v;
            logic f, r, e;
            for (int j = 0; j < N; j++) req_data[j*DW +: DW] = $urandom;
            v = 4'($urandom_range(0, 15));
            f = ($urandom_range(0, 3) == 0);
            r = 1'($urandom_range(0, 1));
            e = (m_level == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
            cycle(v, f, r, e, 0, 0, 0, 0);
        end

        // Reset in the middle of a burst
        cycle(4'hF, 0, 0, 1, 0, 0, 0, 0);
        cycle(4'hF, 0, 0, 1, 0, 0, 0, 0);
        req_valid = 4'hF; fifo_full = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("midrst_wren", 64'(wren), 64'd0);
        check("midrst_ready", 64'(req_ready), 64'd0);
        check("midrst_level", 64'(level), 64'd0);
        model_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
        cycle(4'hF, 0, 0, 1, 1, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
